// File: rtl/hazard_scoreboard_unit.sv
// Per-register busy scoreboard: countdown counters loaded on issue gate the ID stage,
// with forwarding-aware latencies, memory-stall freeze and a saturating stall counter.
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int LAT_NOFWD    = 2,
    parameter int LAT_FWD_LOAD = 1,
    parameter int LAT_FWD_ALU  = 0,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic                         freeze,
    input  logic                         id_valid,
    input  logic [REG_ADDR_W-1:0]        src1,
    input  logic [REG_ADDR_W-1:0]        src2,
    input  logic                         is_single_src,
    input  logic                         is_BNE,
    input  logic [REG_ADDR_W-1:0]        id_dest,
    input  logic                         id_WB_EN,
    input  logic                         id_MEM_R_EN,
    output logic                         hazard_Detected,
    output logic [(2**REG_ADDR_W)-1:0]   busy_mask,
    output logic [STALL_CNT_W-1:0]       stall_count
);

    localparam int NUM_REGS    = 2**REG_ADDR_W;
    localparam int LAT_FWD_MAX = (LAT_FWD_LOAD > LAT_FWD_ALU) ? LAT_FWD_LOAD : LAT_FWD_ALU;
    localparam int LAT_MAX     = (LAT_NOFWD > LAT_FWD_MAX) ? LAT_NOFWD : LAT_FWD_MAX;
    localparam int CNT_W       = ($clog2(LAT_MAX + 32'sd1) < 32'sd1) ? 32'sd1 : $clog2(LAT_MAX + 32'sd1);

    localparam logic [CNT_W-1:0]       CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]       L_NOFWD    = CNT_W'(LAT_NOFWD);
    localparam logic [CNT_W-1:0]       L_FWD_LOAD = CNT_W'(LAT_FWD_LOAD);
    localparam logic [CNT_W-1:0]       L_FWD_ALU  = CNT_W'(LAT_FWD_ALU);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX  = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE  = STALL_CNT_W'(1'b1);

    logic [CNT_W-1:0]       cnt_r      [NUM_REGS];
    logic [CNT_W-1:0]       cnt_next_s [NUM_REGS];
    logic [NUM_REGS-1:0]    busy_s;
    logic [NUM_REGS-1:0]    busy_mask_r;
    logic [STALL_CNT_W-1:0] stall_count_r;
    logic                   uses_src2_s;
    logic                   hazard_s;
    logic                   issue_s;
    logic [CNT_W-1:0]       lat_s;

    // Live busy view of each register; R0 can never be busy.
    always_comb begin
        busy_s = {NUM_REGS{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_s[r] = (cnt_r[r] != CNT_ZERO);
        end
    end

    // Hazard and issue decisions for the instruction sitting in ID.
    always_comb begin
        uses_src2_s = !is_single_src || is_BNE;
        hazard_s    = id_valid && (busy_s[src1] || (uses_src2_s && busy_s[src2]));
        issue_s     = id_valid && !hazard_s && !freeze && id_WB_EN &&
                      (id_dest != {REG_ADDR_W{1'b0}});
    end

    // Busy latency for the issuing writer.
    always_comb begin
        case ({mode, id_MEM_R_EN})
            2'b10:   lat_s = L_FWD_ALU;
            2'b11:   lat_s = L_FWD_LOAD;
            default: lat_s = L_NOFWD;
        endcase
    end

    // Countdown with youngest-writer reload; everything holds while frozen.
    always_comb begin
        if (!freeze) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (issue_s && (id_dest == REG_ADDR_W'(r))) begin
                    cnt_next_s[r] = lat_s;
                end else if (cnt_r[r] != CNT_ZERO) begin
                    cnt_next_s[r] = cnt_r[r] - CNT_ONE;
                end else begin
                    cnt_next_s[r] = cnt_r[r];
                end
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_next_s[r] = cnt_r[r];
            end
        end
    end

    // Scoreboard state, registered busy mask and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
            busy_mask_r   <= {NUM_REGS{1'b0}};
            stall_count_r <= {STALL_CNT_W{1'b0}};
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= cnt_next_s[r];
            end
            busy_mask_r[0] <= 1'b0;
            for (int r = 1; r < NUM_REGS; r++) begin
                busy_mask_r[r] <= (cnt_next_s[r] != CNT_ZERO);
            end
            if (hazard_s && !freeze && (stall_count_r != STALL_MAX)) begin
                stall_count_r <= stall_count_r + STALL_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign hazard_Detected = hazard_s;
    assign busy_mask       = busy_mask_r;
    assign stall_count     = stall_count_r;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed self-checking bench for hazard_scoreboard_unit (4-bit stall counter build).
module tb_hazard_scoreboard_unit;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        freeze;
    logic        id_valid;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        is_single_src;
    logic        is_BNE;
    logic [4:0]  id_dest;
    logic        id_WB_EN;
    logic        id_MEM_R_EN;
    logic        hazard_Detected;
    logic [31:0] busy_mask;
    logic [3:0]  stall_count;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard_unit #(
        .REG_ADDR_W   (5),
        .LAT_NOFWD    (2),
        .LAT_FWD_LOAD (1),
        .LAT_FWD_ALU  (0),
        .STALL_CNT_W  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mode            (mode),
        .freeze          (freeze),
        .id_valid        (id_valid),
        .src1            (src1),
        .src2            (src2),
        .is_single_src   (is_single_src),
        .is_BNE          (is_BNE),
        .id_dest         (id_dest),
        .id_WB_EN        (id_WB_EN),
        .id_MEM_R_EN     (id_MEM_R_EN),
        .hazard_Detected (hazard_Detected),
        .busy_mask       (busy_mask),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an ID-stage instruction; outputs are then sampled #1 later.
    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic single, input logic bne, input logic [4:0] dest,
                         input logic wb, input logic memr);
        id_valid      = v;
        src1          = s1;
        src2          = s2;
        is_single_src = single;
        is_BNE        = bne;
        id_dest       = dest;
        id_WB_EN      = wb;
        id_MEM_R_EN   = memr;
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        mode   = 1'b0;
        freeze = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b1, 5'd3, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (busy_mask !== 32'h0) begin
            errors++; $display("FAIL reset_busy_mask: got %h want %h", busy_mask, 32'h0);
        end
        checks++;
        if (stall_count !== 4'd0) begin
            errors++; $display("FAIL reset_stall_count: got %0d want %0d", stall_count, 4'd0);
        end
        checks++;
        if (hazard_Detected !== 1'b0) begin
            errors++; $display("FAIL reset_hazard: got %b want %b", hazard_Detected, 1'b0);
        end
    endtask

    task automatic test_nofwd();
        do_reset();
        mode = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
        checks++;
        if (hazard_Detected !== 1'b0) begin
            errors++; $display("FAIL nofwd_issue_hazard: got %b want %b", hazard_Detected, 1'b0);
        end
        tick();
        drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (hazard_Detected !== 1'b1) begin
                errors++; $display("FAIL nofwd_hazard_c%0d: got %b want %b", c, hazard_Detected, 1'b1);
            end
            checks++;
            if (busy_mask !== 32'h0000_0008) begin
                errors++; $display("FAIL nofwd_busy_c%0d: got %h want %h", c, busy_mask, 32'h0000_0008);
            end
            tick();
        end
        checks++;
        if (hazard_Detected !== 1'b0) begin
            errors++; $display("FAIL nofwd_hazard_c3: got %b want %b", hazard_Detected, 1'b0);
        end
        checks++;
        if (stall_count !== 4'd2) begin
            errors++; $display("FAIL nofwd_stall_count: got %0d want %0d", stall_count, 4'd2);
        end
        checks++;
        if (busy_mask !== 32'h0) begin
            errors++; $display("FAIL nofwd_busy_c3: got %h want %h", busy_mask, 32'h0);
        end
    endtask

    task automatic test_fwd();
        do_reset();
        mode = 1'b1;
        drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        // Reader of R4 that is itself a load to R5.
        drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        checks++;
        if (hazard_Detected !== 1'b0) begin
            errors++; $display("FAIL fwd_alu_hazard: got %b want %b", hazard_Detected, 1'b0);
        end
        checks++;
        if (busy_mask !== 32'h0) begin
            errors++; $display("FAIL fwd_alu_busy: got %h want %h", busy_mask, 32'h0);
        end
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (hazard_Detected !== 1'b1) begin
            errors++; $display("FAIL fwd_load_hazard: got %b want %b", hazard_Detected, 1'b1);
        end
        checks++;
        if (busy_mask !== 32'h0000_0020) begin
            errors++; $display("FAIL fwd_load_busy: got %h want %h", busy_mask, 32'h0000_0020);
        end
        tick();
        checks++;
        if (hazard_Detected !== 1'b0) begin
            errors++; $display("FAIL fwd_load_free: got %b want %b", hazard_Detected, 1'b0);
        end
        checks++;
        if (stall_count !== 4'd1) begin
            errors++; $display("FAIL fwd_stall_count: got %0d want %0d", stall_count, 4'd1);
        end
    endtask

    task automatic test_r0();
        do_reset();
        mode = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (hazard_Detected !== 1'b0) begin
                errors++; $display("FAIL r0_hazard_c%0d: got %b want %b", c, hazard_Detected, 1'b0);
            end
            checks++;
            if (busy_mask !== 32'h0) begin
                errors++; $display("FAIL r0_busy_c%0d: got %h want %h", c, busy_mask, 32'h0);
            end
            tick();
        end
    endtask

    task automatic test_src2_gating();
        do_reset();
        mode = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (hazard_Detected !== 1'b0) begin
            errors++; $display("FAIL src2_single_hazard: got %b want %b", hazard_Detected, 1'b0);
        end
        drive(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        checks++;
        if (hazard_Detected !== 1'b1) begin
            errors++; $display("FAIL src2_bne_hazard: got %b want %b", hazard_Detected, 1'b1);
        end
        drive(1'b1, 5'd1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (hazard_Detected !== 1'b1) begin
            errors++; $display("FAIL src2_dual_hazard: got %b want %b", hazard_Detected, 1'b1);
        end
        drive(1'b0, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (hazard_Detected !== 1'b0) begin
            errors++; $display("FAIL src2_invalid_hazard: got %b want %b", hazard_Detected, 1'b0);
        end
    endtask

    task automatic test_freeze_override();
        do_reset();
        mode = 1'b0;
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        tick();
        freeze = 1'b1;
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (hazard_Detected !== 1'b1) begin
                errors++; $display("FAIL freeze_hazard_c%0d: got %b want %b", c, hazard_Detected, 1'b1);
            end
            tick();
        end
        checks++;
        if (stall_count !== 4'd0) begin
            errors++; $display("FAIL freeze_stall_count: got %0d want %0d", stall_count, 4'd0);
        end
        checks++;
        if (busy_mask !== 32'h0000_0040) begin
            errors++; $display("FAIL freeze_busy: got %h want %h", busy_mask, 32'h0000_0040);
        end
        // Load to R6 on the edge where R6 would otherwise count down.
        freeze = 1'b0;
        mode   = 1'b1;
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (hazard_Detected !== 1'b1) begin
            errors++; $display("FAIL override_load_hazard: got %b want %b", hazard_Detected, 1'b1);
        end
        tick();
        checks++;
        if (hazard_Detected !== 1'b0) begin
            errors++; $display("FAIL override_load_free: got %b want %b", hazard_Detected, 1'b0);
        end
        checks++;
        if (stall_count !== 4'd1) begin
            errors++; $display("FAIL override_stall_count: got %0d want %0d", stall_count, 4'd1);
        end
        // ALU writer (L=0) to R6 while R6 counts 2: youngest writer clears it outright.
        mode = 1'b0;
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        tick();
        mode = 1'b1;
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (busy_mask !== 32'h0) begin
            errors++; $display("FAIL override_alu_busy: got %h want %h", busy_mask, 32'h0);
        end
        checks++;
        if (hazard_Detected !== 1'b0) begin
            errors++; $display("FAIL override_alu_hazard: got %b want %b", hazard_Detected, 1'b0);
        end
        // Mode-0 writer to R6 while R6 counts 1: reload to 2 gives two stall cycles.
        mode = 1'b1;
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        mode = 1'b0;
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (hazard_Detected !== 1'b1) begin
            errors++; $display("FAIL override_reload_hazard: got %b want %b", hazard_Detected, 1'b1);
        end
        tick();
        checks++;
        if (hazard_Detected !== 1'b0) begin
            errors++; $display("FAIL override_reload_free: got %b want %b", hazard_Detected, 1'b0);
        end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        mode = 1'b0;
        for (int it = 1; it <= 10; it++) begin
            drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
            tick();
            drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
            tick();
            tick();
            if (it == 7) begin
                checks++;
                if (stall_count !== 4'd14) begin
                    errors++; $display("FAIL sat_stall_14: got %0d want %0d", stall_count, 4'd14);
                end
            end
        end
        checks++;
        if (stall_count !== 4'd15) begin
            errors++; $display("FAIL sat_stall_15: got %0d want %0d", stall_count, 4'd15);
        end
        // Make R9 busy, then pulse reset between clock edges.
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy_mask !== 32'h0) begin
            errors++; $display("FAIL async_rst_busy: got %h want %h", busy_mask, 32'h0);
        end
        checks++;
        if (stall_count !== 4'd0) begin
            errors++; $display("FAIL async_rst_stall: got %0d want %0d", stall_count, 4'd0);
        end
        checks++;
        if (hazard_Detected !== 1'b0) begin
            errors++; $display("FAIL async_rst_hazard: got %b want %b", hazard_Detected, 1'b0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (stall_count !== 4'd0 || hazard_Detected !== 1'b0) begin
            errors++; $display("FAIL post_rst_state: got stall=%0d hazard=%b want stall=0 hazard=0",
                               stall_count, hazard_Detected);
        end
    endtask

    initial begin
        test_reset();
        test_nofwd();
        test_fwd();
        test_r0();
        test_src2_gating();
        test_freeze_override();
        test_saturation_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the pipeline hazard detector.
- Replaces the fixed EXE/MEM destination compares with a per-register busy scoreboard of countdown counters, loaded when an instruction issues from ID to EXE.
- Supports forwarding and non-forwarding modes with programmable latencies, honours memory-stall freeze, never flags R0, and keeps a saturating stall-cycle counter for performance analysis.
- Sits beside the ID stage; its hazard_Detected output gates the PC/IF-ID registers and bubbles ID/EXE.

Parameters:
- REG_ADDR_W, 5: register index width. NUM_REGS = 2**REG_ADDR_W.
- LAT_NOFWD, 2: cycles a destination stays busy after issue when mode=0.
- LAT_FWD_LOAD, 1: busy cycles after a load issues when mode=1.
- LAT_FWD_ALU, 0: busy cycles after a non-load writer issues when mode=1.
- STALL_CNT_W, 16: width of stall_count.
- CNT_W is a derived localparam, not overridable: clog2(max latency + 1), minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = no forwarding, 1 = forwarding enabled.
- freeze  input  1  pipeline frozen by a memory stall.
- id_valid  input  1  ID holds a real (non-flushed) instruction.
- src1  input  REG_ADDR_W  first source register of the ID instruction.
- src2  input  REG_ADDR_W  second source register of the ID instruction.
- is_single_src  input  1  instruction reads src1 only.
- is_BNE  input  1  branch that reads src2 despite is_single_src.
- id_dest  input  REG_ADDR_W  destination of the ID instruction.
- id_WB_EN  input  1  ID instruction writes the register file.
- id_MEM_R_EN  input  1  ID instruction is a load.
- hazard_Detected  output  1  stall ID this cycle (combinational).
- busy_mask  output  NUM_REGS  registered view of counter != 0 per register.
- stall_count  output  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- State: cnt[r] (CNT_W bits) for r = 0..NUM_REGS-1; stall_count register.
- Reset (async, rst=1): all cnt = 0, busy_mask = 0, stall_count = 0. hazard_Detected is therefore 0 unless a combinational src match exists, and none can match when all counters are 0.
- Definitions:
  - busy(r) = (cnt[r] != 0) && (r != 0).
  - uses_src2 = !is_single_src || is_BNE.
- hazard_Detected = id_valid && (busy(src1) || (uses_src2 && busy(src2))). Same-cycle combinational; independent of freeze.
- Issue condition: issue = id_valid && !hazard_Detected && !freeze && id_WB_EN && (id_dest != 0).
- Issue latency L:
  - mode=0: L = LAT_NOFWD.
  - mode=1, id_MEM_R_EN=1: L = LAT_FWD_LOAD.
  - mode=1, otherwise: L = LAT_FWD_ALU.
- Per rising edge, when freeze=0:
  - every nonzero cnt decrements by 1;
  - then, if issue, cnt[id_dest] <= L. The load overrides both the decrement and any older pending value for that register; the youngest writer wins.
- Per rising edge, when freeze=1: all cnt hold; no issue.
- Timing: an instruction issued in cycle t marks its destination busy in cycles t+1 .. t+L. A reader is free in cycle t+L+1. L=0 never marks busy.
- Mode change: takes effect for the next issue only; existing counters keep running.
- busy_mask[r] is cnt[r] != 0 (bit 0 always 0), derived from registered state.
- stall_count: increments on each edge where hazard_Detected && !freeze; saturates at all-ones, with no wrap.
- Flushed instructions are presented with id_valid=0; already-issued entries are never cleared except by countdown or reset.
- Reset asserted mid-operation clears everything immediately; the first cycle after deassert behaves as post-reset.

Test Plan:
- mode=0: issue writer of R3 in cycle 0; present reader src1=R3 from cycle 1 -> hazard_Detected=1 in cycles 1,2 and 0 in cycle 3; stall_count=2.
- mode=1: issue ALU writer of R4, then reader of R4 -> no hazard. Issue load to R5, then reader of R5 -> hazard for exactly 1 cycle.
- R0: writer to R0, then reader src1=src2=R0 -> hazard_Detected=0 and busy_mask=0 throughout.
- src2 gating: R7 busy, src2=R7, is_single_src=1, is_BNE=0 -> hazard_Detected=0. The same with is_BNE=1 -> hazard_Detected=1.
- Freeze and override: R6 issued with cnt=2, freeze=1 for 3 cycles -> cnt holds at 2, hazard stays 1, stall_count does not increment. A new issue to R6 (mode=1 load) on the edge where R6 would decrement -> cnt=1.
- Reset and saturation: with STALL_CNT_W=4, hold a hazard for 20 cycles -> stall_count=15. Pulse rst asynchronously mid-clock -> busy_mask=0 and stall_count=0 immediately.
